// File: rtl/mesi_arb_pkg.sv
// Shared types for the MESI common-bus arbiter.
// Owner class encoding doubles as the gnt_class output value.
package mesi_arb_pkg;

    typedef enum logic [1:0] {
        CLS_NONE  = 2'd0,
        CLS_MEM   = 2'd1,
        CLS_SNOOP = 2'd2,
        CLS_PROC  = 2'd3
    } arb_class_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam logic [1:0] CLS_W = 2'd2;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping.
// Purely combinational; the caller owns the pointer register.
module rr_picker #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            automatic int j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                idx    = IW'(j);
                gnt[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mesi_bus_arbiter_rr.sv
// Common-bus arbiter: mem > snoop > proc, RR within classes.
// Grants are registered and held until the owner drops its request.
import mesi_arb_pkg::*;

module mesi_bus_arbiter_rr #(
    parameter int NUM_CORES = 4,
    parameter int MAX_HOLD  = 16,
    localparam int IW = $clog2(NUM_CORES),
    localparam int CW = $clog2(MAX_HOLD + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CORES-1:0] com_bus_req_proc,
    input  logic [NUM_CORES-1:0] com_bus_req_snoop,
    input  logic                 mem_snoop_req,
    input  logic                 err_clr,
    output logic [NUM_CORES-1:0] com_bus_gnt_proc,
    output logic [NUM_CORES-1:0] com_bus_gnt_snoop,
    output logic                 mem_snoop_gnt,
    output logic                 bus_busy,
    output logic [1:0]           gnt_class,
    output logic [IW-1:0]        gnt_id,
    output logic                 hold_err
);

    arb_state_e           state, state_d;
    arb_class_e           own_cls, cls_d;
    logic [IW-1:0]        own_id, id_d;
    logic [IW-1:0]        ptr_snoop, ptr_snoop_d;
    logic [IW-1:0]        ptr_proc, ptr_proc_d;
    logic [CW-1:0]        hold_cnt, cnt_d;
    logic                 err_d;
    logic [NUM_CORES-1:0] gp_q, gp_d, gs_q, gs_d;
    logic                 gm_q, gm_d;

    logic [NUM_CORES-1:0] s_gnt, p_gnt;
    logic [IW-1:0]        s_idx, p_idx;
    logic                 s_any, p_any;
    logic                 owner_req;
    logic                 arb_en;

    rr_picker #(.N(NUM_CORES)) u_snoop (
        .req (com_bus_req_snoop),
        .ptr (ptr_snoop),
        .gnt (s_gnt),
        .idx (s_idx),
        .any (s_any)
    );

    rr_picker #(.N(NUM_CORES)) u_proc (
        .req (com_bus_req_proc),
        .ptr (ptr_proc),
        .gnt (p_gnt),
        .idx (p_idx),
        .any (p_any)
    );

    always_comb begin
        owner_req = 1'b0;
        case (own_cls)
            CLS_MEM:   owner_req = mem_snoop_req;
            CLS_SNOOP: owner_req = com_bus_req_snoop[own_id];
            CLS_PROC:  owner_req = com_bus_req_proc[own_id];
            default:   owner_req = 1'b0;
        endcase
    end

    assign arb_en = (state == ST_IDLE) || !owner_req;

    always_comb begin
        state_d     = state;
        cls_d       = own_cls;
        id_d        = own_id;
        ptr_snoop_d = ptr_snoop;
        ptr_proc_d  = ptr_proc;
        cnt_d       = hold_cnt;
        gp_d        = gp_q;
        gs_d        = gs_q;
        gm_d        = gm_q;
        err_d       = hold_err & ~err_clr;
        if (arb_en) begin
            cnt_d = '0;
            gp_d  = '0;
            gs_d  = '0;
            gm_d  = 1'b0;
            id_d  = '0;
            if (mem_snoop_req) begin
                state_d = ST_GRANT;
                cls_d   = CLS_MEM;
                gm_d    = 1'b1;
            end else if (s_any) begin
                state_d     = ST_GRANT;
                cls_d       = CLS_SNOOP;
                id_d        = s_idx;
                gs_d        = s_gnt;
                ptr_snoop_d = (s_idx == IW'(NUM_CORES - 1)) ? '0 : s_idx + 1'b1;
            end else if (p_any) begin
                state_d    = ST_GRANT;
                cls_d      = CLS_PROC;
                id_d       = p_idx;
                gp_d       = p_gnt;
                ptr_proc_d = (p_idx == IW'(NUM_CORES - 1)) ? '0 : p_idx + 1'b1;
            end else begin
                state_d = ST_IDLE;
                cls_d   = CLS_NONE;
            end
        end else begin
            // owner still holding: count toward the watchdog, set wins over clear
            if (hold_cnt != CW'(MAX_HOLD))
                cnt_d = hold_cnt + 1'b1;
            if (hold_cnt == CW'(MAX_HOLD - 1))
                err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            own_cls   <= CLS_NONE;
            own_id    <= '0;
            ptr_snoop <= '0;
            ptr_proc  <= '0;
            hold_cnt  <= '0;
            hold_err  <= 1'b0;
            gp_q      <= '0;
            gs_q      <= '0;
            gm_q      <= 1'b0;
        end else begin
            state     <= state_d;
            own_cls   <= cls_d;
            own_id    <= id_d;
            ptr_snoop <= ptr_snoop_d;
            ptr_proc  <= ptr_proc_d;
            hold_cnt  <= cnt_d;
            hold_err  <= err_d;
            gp_q      <= gp_d;
            gs_q      <= gs_d;
            gm_q      <= gm_d;
        end
    end

    assign com_bus_gnt_proc  = gp_q;
    assign com_bus_gnt_snoop = gs_q;
    assign mem_snoop_gnt     = gm_q;
    assign bus_busy          = (own_cls != CLS_NONE);
    assign gnt_class         = own_cls;
    assign gnt_id            = own_id;

endmodule

// File: tb/tb_mesi_bus_arbiter_rr.sv
// Directed bench for mesi_bus_arbiter_rr with an expected-value queue.
// NUM_CORES=4, MAX_HOLD=8.
module tb_mesi_bus_arbiter_rr;

    typedef struct packed {
        logic [3:0] gp;
        logic [3:0] gs;
        logic       gm;
        logic       busy;
        logic [1:0] cls;
        logic [1:0] id;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_proc;
    logic [3:0] req_snoop;
    logic       mem_req;
    logic       err_clr;
    logic [3:0] gnt_proc;
    logic [3:0] gnt_snoop;
    logic       mem_gnt;
    logic       bus_busy;
    logic [1:0] gnt_class;
    logic [1:0] gnt_id;
    logic       hold_err;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    mesi_bus_arbiter_rr #(.NUM_CORES(4), .MAX_HOLD(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .com_bus_req_proc  (req_proc),
        .com_bus_req_snoop (req_snoop),
        .mem_snoop_req     (mem_req),
        .err_clr           (err_clr),
        .com_bus_gnt_proc  (gnt_proc),
        .com_bus_gnt_snoop (gnt_snoop),
        .mem_snoop_gnt     (mem_gnt),
        .bus_busy          (bus_busy),
        .gnt_class         (gnt_class),
        .gnt_id            (gnt_id),
        .hold_err          (hold_err)
    );

    task automatic chk(input string t, input logic [7:0] obs, input logic [7:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", t, obs, req);
        end
    endtask

    task automatic expect_out(input string t, input logic [3:0] gp, input logic [3:0] gs,
                              input logic gm, input logic [1:0] cls, input logic [1:0] id,
                              input logic err);
        exp_t e;
        e.gp   = gp;
        e.gs   = gs;
        e.gm   = gm;
        e.busy = (gp != 4'd0) || (gs != 4'd0) || gm;
        e.cls  = cls;
        e.id   = id;
        e.err  = err;
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic check_now();
        exp_t  e;
        string t;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk({t, ".gnt_proc"},  {4'd0, gnt_proc},  {4'd0, e.gp});
        chk({t, ".gnt_snoop"}, {4'd0, gnt_snoop}, {4'd0, e.gs});
        chk({t, ".mem_gnt"},   {7'd0, mem_gnt},   {7'd0, e.gm});
        chk({t, ".bus_busy"},  {7'd0, bus_busy},  {7'd0, e.busy});
        chk({t, ".gnt_class"}, {6'd0, gnt_class}, {6'd0, e.cls});
        chk({t, ".gnt_id"},    {6'd0, gnt_id},    {6'd0, e.id});
        chk({t, ".hold_err"},  {7'd0, hold_err},  {7'd0, e.err});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_now();
    endtask

    localparam logic [1:0] NONE = 2'd0, MEM = 2'd1, SNP = 2'd2, PRC = 2'd3;

    initial begin
        rst       = 1'b0;
        req_proc  = '0;
        req_snoop = '0;
        mem_req   = 1'b0;
        err_clr   = 1'b0;
        #12;
        expect_out("reset", 4'h0, 4'h0, 0, NONE, 2'd0, 0);
        check_now();
        @(negedge clk);
        rst = 1'b1;

        req_proc = 4'b0001;
        expect_out("p0_grant", 4'b0001, 4'h0, 0, PRC, 2'd0, 0);
        tick();
        req_proc = 4'b0000;
        expect_out("p0_release", 4'h0, 4'h0, 0, NONE, 2'd0, 0);
        tick();

        req_proc = 4'b1010;
        expect_out("rr_p1", 4'b0010, 4'h0, 0, PRC, 2'd1, 0);
        tick();
        expect_out("rr_p1_hold", 4'b0010, 4'h0, 0, PRC, 2'd1, 0);
        tick();
        req_proc = 4'b1000;
        expect_out("rr_handover_p3", 4'b1000, 4'h0, 0, PRC, 2'd3, 0);
        tick();
        req_proc = 4'b0010;
        expect_out("rr_wrap_p1", 4'b0010, 4'h0, 0, PRC, 2'd1, 0);
        tick();
        req_proc = 4'b0000;
        expect_out("rr_idle", 4'h0, 4'h0, 0, NONE, 2'd0, 0);
        tick();

        req_proc  = 4'b0100;
        req_snoop = 4'b0010;
        mem_req   = 1'b1;
        expect_out("class_mem", 4'h0, 4'h0, 1, MEM, 2'd0, 0);
        tick();
        mem_req = 1'b0;
        expect_out("class_snoop", 4'h0, 4'b0010, 0, SNP, 2'd1, 0);
        tick();
        req_snoop = 4'b0000;
        expect_out("class_proc", 4'b0100, 4'h0, 0, PRC, 2'd2, 0);
        tick();
        req_proc = 4'b0000;
        expect_out("class_idle", 4'h0, 4'h0, 0, NONE, 2'd0, 0);
        tick();

        req_proc = 4'b0001;
        expect_out("np_p0", 4'b0001, 4'h0, 0, PRC, 2'd0, 0);
        tick();
        mem_req = 1'b1;
        expect_out("np_hold", 4'b0001, 4'h0, 0, PRC, 2'd0, 0);
        tick();
        req_proc = 4'b0000;
        expect_out("np_mem", 4'h0, 4'h0, 1, MEM, 2'd0, 0);
        tick();
        mem_req = 1'b0;
        expect_out("np_idle", 4'h0, 4'h0, 0, NONE, 2'd0, 0);
        tick();

        req_proc = 4'b1000;
        expect_out("wd_grant", 4'b1000, 4'h0, 0, PRC, 2'd3, 0);
        tick();
        for (int i = 1; i < 8; i++) begin
            expect_out($sformatf("wd_cnt%0d", i), 4'b1000, 4'h0, 0, PRC, 2'd3, 0);
            tick();
        end
        expect_out("wd_set", 4'b1000, 4'h0, 0, PRC, 2'd3, 1);
        tick();
        for (int i = 0; i < 2; i++) begin
            expect_out($sformatf("wd_sticky%0d", i), 4'b1000, 4'h0, 0, PRC, 2'd3, 1);
            tick();
        end
        err_clr = 1'b1;
        expect_out("wd_clear", 4'b1000, 4'h0, 0, PRC, 2'd3, 0);
        tick();
        err_clr = 1'b0;

        #2;
        rst = 1'b0;
        #1;
        expect_out("async_rst", 4'h0, 4'h0, 0, NONE, 2'd0, 0);
        check_now();
        req_proc = 4'b0000;
        @(negedge clk);
        rst       = 1'b1;
        req_snoop = 4'b0101;
        expect_out("ptr_reset", 4'h0, 4'b0001, 0, SNP, 2'd0, 0);
        tick();
        req_snoop = 4'b0000;
        expect_out("final_idle", 4'h0, 4'h0, 0, NONE, 2'd0, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
